// File: rtl/spmv_arb_pkg.sv
// Shared types and width helper for the SpMV stream arbiter.
package spmv_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Width of a field that must hold values 0..n-1; never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spmv_rr_picker.sv
// Round-robin scan: first asserted req at or after ptr, wrapping modulo NUM_REQ.
// Purely combinational; found is low when no request is asserted.
module spmv_rr_picker
    import spmv_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = clog2w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_WIDTH:0]    ptr_ext;
    logic [ID_WIDTH-1:0]  pos;
    logic [ID_WIDTH:0]    sum;

    // Rotating through a doubled copy puts position ptr at bit 0.
    assign dbl     = {req, req};
    assign ptr_ext = {1'b0, ptr};
    assign rot     = dbl[ptr_ext +: NUM_REQ];

    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos   = ID_WIDTH'(j);
                found = 1'b1;
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, pos};
    assign idx = (sum >= (ID_WIDTH + 1)'(NUM_REQ)) ? ID_WIDTH'(sum - (ID_WIDTH + 1)'(NUM_REQ))
                                                   : sum[ID_WIDTH-1:0];

endmodule

// File: rtl/spmv_stream_arbiter.sv
// Round-robin burst arbiter feeding the SpMV demux: one dead cycle per grant, then zero-latency pass-through tagged with m_id.
// Only the granted source sees m_ready; SPMV_ARB_IDLE_RELEASE_EN adds release of a grant stalled for IDLE_TIMEOUT cycles.
module spmv_stream_arbiter
    import spmv_arb_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  DATA_WIDTH   = 256,
    parameter int  MAX_BURST    = 16,
    parameter int  IDLE_TIMEOUT = 8,
    localparam int ID_WIDTH     = clog2w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    output logic                          m_last,
    output logic [ID_WIDTH-1:0]           m_id,
    input  logic                          m_ready,
    output logic                          busy
);

    localparam int                  CNT_W    = clog2w(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] TOP_ID   = ID_WIDTH'(NUM_REQ - 1);

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] grant, grant_nxt;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0] grant_inc;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                cur_valid;
    logic                last_beat;
    logic                xfer;

`ifdef SPMV_ARB_IDLE_RELEASE_EN
    localparam int               STALL_W   = clog2w(IDLE_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_END = STALL_W'(IDLE_TIMEOUT - 1);
    logic [STALL_W-1:0] stall_cnt, stall_nxt;
`endif

    spmv_rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req   (s_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_valid = s_valid[grant];
    assign last_beat = cur_valid & (s_last[grant] | (beat_cnt == LAST_CNT));
    assign xfer      = (state == GRANT) & cur_valid & m_ready;
    assign grant_inc = (grant == TOP_ID) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
`ifdef SPMV_ARB_IDLE_RELEASE_EN
            stall_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
`ifdef SPMV_ARB_IDLE_RELEASE_EN
            stall_cnt <= stall_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
`ifdef SPMV_ARB_IDLE_RELEASE_EN
        stall_nxt    = stall_cnt;
`endif
        case (state)
            IDLE: begin
`ifdef SPMV_ARB_IDLE_RELEASE_EN
                stall_nxt = '0;
`endif
                if (pick_found) begin
                    state_nxt    = GRANT;
                    grant_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (last_beat) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_inc;
                    end
                end
`ifdef SPMV_ARB_IDLE_RELEASE_EN
                // Release on the edge at which the stall count would reach IDLE_TIMEOUT.
                if (xfer) begin
                    stall_nxt = '0;
                end else if (!cur_valid) begin
                    if (stall_cnt == STALL_END) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_inc;
                        stall_nxt  = '0;
                    end else begin
                        stall_nxt = stall_cnt + 1'b1;
                    end
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_id    = '0;
        busy    = 1'b0;
        if (state == GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant == ID_WIDTH'(i)) begin
                    m_data     = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                    s_ready[i] = m_ready;
                end
            end
            m_valid = cur_valid;
            m_last  = last_beat;
            m_id    = grant;
            busy    = 1'b1;
        end
    end

endmodule

// File: tb/tb_spmv_stream_arbiter.sv
// Directed bench for spmv_stream_arbiter: bench-side stream sources, recorded handshakes, hand-computed expectations.
module tb_spmv_stream_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int IT = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR*DW-1:0]  s_data;
    logic [NR-1:0]     s_valid;
    logic [NR-1:0]     s_last;
    logic [NR-1:0]     s_ready;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_last;
    logic [IW-1:0]     m_id;
    logic              m_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [DW-1:0] q_dat [NR][$];
    bit            q_lst [NR][$];
    bit            en    [NR];
    bit            rdy_toggle = 1'b0;

    logic [DW-1:0] o_dat [$];
    logic [IW-1:0] o_id  [$];
    bit            o_lst [$];
    int            o_cyc [$];

    always #5 clk = ~clk;

    spmv_stream_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_id    (m_id),
        .m_ready (m_ready),
        .busy    (busy)
    );

    task automatic drive();
        s_data  = '0;
        s_valid = '0;
        s_last  = '0;
        for (int i = 0; i < NR; i++) begin
            if (en[i] && q_dat[i].size() > 0) begin
                s_data[i*DW +: DW] = q_dat[i][0];
                s_valid[i]         = 1'b1;
                s_last[i]          = q_lst[i][0];
            end
        end
        m_ready = rdy_toggle ? (((cyc - t0) % 2) == 0) : 1'b1;
    endtask

    // One clock: present heads, record any handshake, pop accepted heads after the edge.
    task automatic step();
        logic [NR-1:0] pop;
        drive();
        #1;
        pop = s_ready & s_valid;
        if (m_valid && m_ready) begin
            o_dat.push_back(m_data);
            o_id.push_back(m_id);
            o_lst.push_back(m_last);
            o_cyc.push_back(cyc - t0);
            checks++;
            if (pop !== (NR'(1) << m_id)) begin
                errors++;
                $display("FAIL handshake_ready cyc=%0d accepted=%b required=%b", cyc, pop, NR'(1) << m_id);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (pop[i]) begin
                void'(q_dat[i].pop_front());
                void'(q_lst[i].pop_front());
            end
        end
    endtask

    task automatic clear_obs();
        o_dat.delete();
        o_id.delete();
        o_lst.delete();
        o_cyc.delete();
        t0 = cyc;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NR; i++) begin
            q_dat[i].delete();
            q_lst[i].delete();
            en[i] = 1'b1;
        end
    endtask

    task automatic load(input int src, input logic [DW-1:0] d, input bit l);
        q_dat[src].push_back(d);
        q_lst[src].push_back(l);
    endtask

    task automatic test_reset();
        drive();
        #1;
        checks++;
        if ({m_valid, m_last, busy, m_id, s_ready, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%b busy=%b id=%0d rdy=%b data=%h want all zero",
                     m_valid, m_last, busy, m_id, s_ready, m_data);
        end
        rstn = 1'b1;
        clear_obs();
        repeat (3) step();
        checks++;
        if (o_dat.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got transfers=%0d busy=%b want 0 0", o_dat.size(), busy);
        end
    endtask

    task automatic test_single();
        clear_obs();
        for (int k = 0; k < 3; k++) load(2, 32'hA000_0000 + k, k == 2);
        repeat (6) step();
        checks++;
        if (o_dat.size() != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_count got %0d busy=%b want 3 busy=0", o_dat.size(), busy);
        end
        for (int k = 0; k < 3 && k < o_dat.size(); k++) begin
            checks++;
            if (o_dat[k] !== 32'hA000_0000 + k || o_id[k] !== 2'd2 || o_lst[k] !== (k == 2) || o_cyc[k] != k + 1) begin
                errors++;
                $display("FAIL single_beat%0d got d=%h id=%0d l=%b c=%0d want d=%h id=2 l=%b c=%0d",
                         k, o_dat[k], o_id[k], o_lst[k], o_cyc[k], 32'hA000_0000 + k, k == 2, k + 1);
            end
        end
    endtask

    task automatic test_alternate();
        clear_obs();
        for (int j = 0; j < 4; j++) begin
            load(0, 32'hB000_0000 + j, j % 2 == 1);
            load(1, 32'hC000_0000 + j, j % 2 == 1);
        end
        repeat (14) step();
        checks++;
        if (o_dat.size() != 8) begin
            errors++;
            $display("FAIL alt_count got %0d want 8", o_dat.size());
        end
        for (int k = 0; k < 8 && k < o_dat.size(); k++) begin
            int            id;
            int            j;
            int            c;
            logic [DW-1:0] d;
            id = (k / 2) % 2;
            j  = (k / 4) * 2 + k % 2;
            c  = 3 * (k / 2) + 1 + k % 2;
            d  = (id == 0) ? 32'hB000_0000 + j : 32'hC000_0000 + j;
            checks++;
            if (o_dat[k] !== d || o_id[k] !== IW'(id) || o_lst[k] !== (k % 2 == 1) || o_cyc[k] != c) begin
                errors++;
                $display("FAIL alt_beat%0d got d=%h id=%0d l=%b c=%0d want d=%h id=%0d l=%b c=%0d",
                         k, o_dat[k], o_id[k], o_lst[k], o_cyc[k], d, id, k % 2 == 1, c);
            end
        end
    endtask

    task automatic test_rr_wrap();
        clear_obs();
        load(0, 32'hE000_0000, 1'b1);
        load(3, 32'hE000_0003, 1'b1);
        repeat (6) step();
        checks++;
        if (o_dat.size() != 2) begin
            errors++;
            $display("FAIL wrap_count got %0d want 2", o_dat.size());
        end else begin
            checks++;
            if (o_id[0] !== 2'd3 || o_dat[0] !== 32'hE000_0003 || o_cyc[0] != 1 ||
                o_id[1] !== 2'd0 || o_dat[1] !== 32'hE000_0000 || o_cyc[1] != 3) begin
                errors++;
                $display("FAIL wrap_order got id=%0d,%0d c=%0d,%0d want id=3,0 c=1,3",
                         o_id[0], o_id[1], o_cyc[0], o_cyc[1]);
            end
        end
    endtask

    task automatic test_max_burst();
        clear_obs();
        for (int j = 1; j <= 20; j++) load(0, 32'hF000_0000 + j, j == 20);
        repeat (26) step();
        checks++;
        if (o_dat.size() != 20 || q_dat[0].size() != 0) begin
            errors++;
            $display("FAIL maxb_count got %0d left=%0d want 20 left=0", o_dat.size(), q_dat[0].size());
        end
        for (int k = 0; k < 20 && k < o_dat.size(); k++) begin
            int j;
            int c;
            bit l;
            j = k + 1;
            c = (j <= MB) ? j : j + 1;
            l = (j == MB) || (j == 20);
            checks++;
            if (o_dat[k] !== 32'hF000_0000 + j || o_id[k] !== 2'd0 || o_lst[k] !== l || o_cyc[k] != c) begin
                errors++;
                $display("FAIL maxb_beat%0d got d=%h id=%0d l=%b c=%0d want d=%h id=0 l=%b c=%0d",
                         j, o_dat[k], o_id[k], o_lst[k], o_cyc[k], 32'hF000_0000 + j, l, c);
            end
        end
    endtask

    task automatic test_ready_toggle();
        clear_obs();
        rdy_toggle = 1'b1;
        for (int j = 0; j < 4; j++) load(1, 32'h6000_0000 + j, j == 3);
        repeat (12) step();
        rdy_toggle = 1'b0;
        checks++;
        if (o_dat.size() != 4 || q_dat[1].size() != 0) begin
            errors++;
            $display("FAIL toggle_count got %0d left=%0d want 4 left=0", o_dat.size(), q_dat[1].size());
        end
        for (int k = 0; k < 4 && k < o_dat.size(); k++) begin
            checks++;
            if (o_dat[k] !== 32'h6000_0000 + k || o_id[k] !== 2'd1 || o_lst[k] !== (k == 3) || o_cyc[k] != 2 * k + 2) begin
                errors++;
                $display("FAIL toggle_beat%0d got d=%h id=%0d l=%b c=%0d want d=%h id=1 l=%b c=%0d",
                         k, o_dat[k], o_id[k], o_lst[k], o_cyc[k], 32'h6000_0000 + k, k == 3, 2 * k + 2);
            end
        end
    endtask

    task automatic test_reset_midburst();
        clear_obs();
        for (int j = 0; j < 5; j++) load(2, 32'h7000_0000 + j, j == 4);
        repeat (2) step();
        drive();
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h7000_0001 || m_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_beat2 got v=%b d=%h id=%0d want v=1 d=70000001 id=2", m_valid, m_data, m_id);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, busy, m_id, s_ready, m_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got v=%b l=%b busy=%b id=%0d rdy=%b data=%h want all zero",
                     m_valid, m_last, busy, m_id, s_ready, m_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        clear_queues();
        rstn = 1'b1;
        clear_obs();
        load(3, 32'h7300_0000, 1'b1);
        load(1, 32'h7100_0000, 1'b1);
        repeat (6) step();
        checks++;
        if (o_dat.size() != 2) begin
            errors++;
            $display("FAIL post_reset_count got %0d want 2", o_dat.size());
        end else begin
            checks++;
            if (o_id[0] !== 2'd1 || o_dat[0] !== 32'h7100_0000 || o_cyc[0] != 1 || o_id[1] !== 2'd3 || o_cyc[1] != 3) begin
                errors++;
                $display("FAIL post_reset_order got id=%0d,%0d c=%0d,%0d want id=1,3 c=1,3",
                         o_id[0], o_id[1], o_cyc[0], o_cyc[1]);
            end
        end
    endtask

    task automatic test_stall();
        rstn = 1'b0;
        #1;
        @(posedge clk);
        #1;
        cyc++;
        clear_queues();
        rstn = 1'b1;
        clear_obs();
        load(1, 32'h8100_0000, 1'b0);
        load(1, 32'h8100_0001, 1'b1);
        load(3, 32'h8300_0000, 1'b1);
        repeat (2) step();
        en[1] = 1'b0;
        repeat (12) step();
`ifdef SPMV_ARB_IDLE_RELEASE_EN
        checks++;
        if (o_dat.size() != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_count got %0d busy=%b want 2 busy=0", o_dat.size(), busy);
        end else begin
            checks++;
            if (o_id[0] !== 2'd1 || o_cyc[0] != 1 || o_lst[0] !== 1'b0 ||
                o_id[1] !== 2'd3 || o_dat[1] !== 32'h8300_0000 || o_cyc[1] != 1 + IT + 2) begin
                errors++;
                $display("FAIL stall_release_order got id=%0d,%0d c=%0d,%0d want id=1,3 c=1,%0d",
                         o_id[0], o_id[1], o_cyc[0], o_cyc[1], 1 + IT + 2);
            end
        end
`else
        checks++;
        if (o_dat.size() != 1 || busy !== 1'b1 || m_id !== 2'd1) begin
            errors++;
            $display("FAIL stall_hold got transfers=%0d busy=%b id=%0d want 1 1 1", o_dat.size(), busy, m_id);
        end
        en[1] = 1'b1;
        repeat (6) step();
        checks++;
        if (o_dat.size() != 3) begin
            errors++;
            $display("FAIL stall_resume_count got %0d want 3", o_dat.size());
        end else begin
            checks++;
            if (o_id[1] !== 2'd1 || o_dat[1] !== 32'h8100_0001 || o_lst[1] !== 1'b1 || o_cyc[1] != 14 ||
                o_id[2] !== 2'd3 || o_cyc[2] != 16) begin
                errors++;
                $display("FAIL stall_resume_order got id=%0d,%0d c=%0d,%0d want id=1,3 c=14,16",
                         o_id[1], o_id[2], o_cyc[1], o_cyc[2]);
            end
        end
`endif
        clear_queues();
    endtask

    initial begin
        rstn = 1'b0;
        clear_queues();
        drive();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_rr_wrap();
        test_max_burst();
        test_ready_toggle();
        test_reset_midburst();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete by t=%0t", $time);
        $fatal(1);
    end

endmodule
